// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  localparam int unsigned MUL_N_DEFAULT = 8;

  localparam req_id_t RST_PTR    = REQ0;
  localparam req_id_t RST_RES_ID = REQ0;
  localparam logic    RST_VALID  = 1'b0;

endpackage

// File: rtl/mul_arbiter_2_mul.sv
// Combinational n x n -> 2n multiplier, two's-complement or unsigned per signed_mul.
module signed_or_unsigned_mul
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned n = MUL_N_DEFAULT
) (
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic [2*n-1:0] res
);

  logic [2*n-1:0] a_ext;
  logic [2*n-1:0] b_ext;

  // The low 2n bits of the extended product equal the true product in either mode.
  always_comb begin
    a_ext = signed_mul ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
    b_ext = signed_mul ? {{n{b[n-1]}}, b} : {{n{1'b0}}, b};
    res   = a_ext * b_ext;
  end

endmodule

// File: rtl/mul_arbiter_2.sv
// Round-robin arbiter sharing one multiplier between two requesters.
// Define MUL_ARBITER_PIPE_EN to add an operand-register stage (latency 2 instead of 1).
module mul_arbiter_2
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned n = MUL_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [n-1:0]   req0_a,
  input  logic [n-1:0]   req0_b,
  input  logic           req0_signed,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [n-1:0]   req1_a,
  input  logic [n-1:0]   req1_b,
  input  logic           req1_signed,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*n-1:0] res,
  output logic           res_id
);

  req_id_t        ptr_q, ptr_d, gnt_id, mul_id;
  logic           out_adv, in_adv, accept;
  logic [n-1:0]   sel_a, sel_b, mul_a, mul_b;
  logic           sel_signed, mul_signed, mul_valid;
  logic [2*n-1:0] prod;
  logic           res_valid_q, res_valid_d;
  logic [2*n-1:0] res_q, res_d;
  req_id_t        res_id_q, res_id_d;

`ifdef MUL_ARBITER_PIPE_EN
  logic           s1_valid_q, s1_valid_d;
  logic [n-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic           s1_signed_q, s1_signed_d;
  req_id_t        s1_id_q, s1_id_d;
`endif

  always_comb begin
    out_adv = !res_valid_q || res_ready;
`ifdef MUL_ARBITER_PIPE_EN
    in_adv = !s1_valid_q || out_adv;
`else
    in_adv = out_adv;
`endif
    if (req0_valid && req1_valid) gnt_id = ptr_q;
    else if (req1_valid)          gnt_id = REQ1;
    else                          gnt_id = REQ0;
    accept     = rst_n && in_adv && (req0_valid || req1_valid);
    req0_ready = accept && (gnt_id == REQ0);
    req1_ready = accept && (gnt_id == REQ1);
    sel_a      = (gnt_id == REQ1) ? req1_a : req0_a;
    sel_b      = (gnt_id == REQ1) ? req1_b : req0_b;
    sel_signed = (gnt_id == REQ1) ? req1_signed : req0_signed;
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_id == REQ0) ? REQ1 : REQ0;
  end

`ifdef MUL_ARBITER_PIPE_EN
  // Operand stage advances whenever it is empty or the output stage moves.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_signed_d = s1_signed_q;
    s1_id_d     = s1_id_q;
    if (in_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d      = sel_a;
        s1_b_d      = sel_b;
        s1_signed_d = sel_signed;
        s1_id_d     = gnt_id;
      end
    end
    mul_a      = s1_a_q;
    mul_b      = s1_b_q;
    mul_signed = s1_signed_q;
    mul_valid  = s1_valid_q;
    mul_id     = s1_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= RST_VALID;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_signed_q <= 1'b0;
      s1_id_q     <= RST_RES_ID;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_signed_q <= s1_signed_d;
      s1_id_q     <= s1_id_d;
    end
  end
`else
  always_comb begin
    mul_a      = sel_a;
    mul_b      = sel_b;
    mul_signed = sel_signed;
    mul_valid  = accept;
    mul_id     = gnt_id;
  end
`endif

  signed_or_unsigned_mul #(.n(n)) u_mul (
    .a          (mul_a),
    .b          (mul_b),
    .signed_mul (mul_signed),
    .res        (prod)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    if (out_adv) begin
      res_valid_d = mul_valid;
      if (mul_valid) begin
        res_d    = prod;
        res_id_d = mul_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= RST_PTR;
      res_valid_q <= RST_VALID;
      res_q       <= '0;
      res_id_q    <= RST_RES_ID;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign res_id    = res_id_q;

endmodule
